// File: rtl/tcm_write_arbiter.sv
// -----------------------------------------------------------------------------
// tcm_write_arbiter
//
// Sequences every write into the dual-copy TCM (one DTCM and one ITCM image of
// the same address space). The DTCM store port is shared between the core
// store path and an external loader. Every loader beat is written into both
// copies. The core is held in BOOT until the loader delivers its last beat.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   st_req_i/addr/data/mask  core store request (level, held until st_done_o)
//   st_done_o                one-cycle pulse in the cycle the store is written
//   ld_valid_i/ready_o       loader handshake (ready is combinational)
//   ld_waddr_i/data/last     loader word address, data, final-boot-beat flag
//   core_hold_o              keeps the core stalled while in BOOT
//   dtcm_we/be/addr/data_o   DTCM write port (registered)
//   itcm_we/addr/data_o      ITCM write port (registered)
//   itcm_stale_o             only with TCM_ITCM_STORE_MIRROR_EN
//
// Optional feature macro: TCM_ITCM_STORE_MIRROR_EN
//   Defined: full-mask core stores are mirrored into the ITCM. Partial-mask
//   stores cannot be mirrored because the ITCM has no byte enables. They set
//   a dirty flag (exported as itcm_stale_o). The flag clears when the loader
//   next writes that address.
// -----------------------------------------------------------------------------
module tcm_write_arbiter #(
    parameter int unsigned WORD_AW   = 14,
    parameter int unsigned MAX_WAIT  = 4,
    parameter bit          BOOT_HOLD = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               st_req_i,
    input  logic [31:0]        st_addr_i,
    input  logic [31:0]        st_data_i,
    input  logic [3:0]         st_mask_i,
    output logic               st_done_o,
    input  logic               ld_valid_i,
    output logic               ld_ready_o,
    input  logic [WORD_AW-1:0] ld_waddr_i,
    input  logic [31:0]        ld_data_i,
    input  logic               ld_last_i,
    output logic               core_hold_o,
    output logic               dtcm_we_o,
    output logic [3:0]         dtcm_be_o,
    output logic [WORD_AW-1:0] dtcm_addr_o,
    output logic [31:0]        dtcm_data_o,
    output logic               itcm_we_o,
    output logic [WORD_AW-1:0] itcm_addr_o,
    output logic [31:0]        itcm_data_o
`ifdef TCM_ITCM_STORE_MIRROR_EN
    ,
    output logic               itcm_stale_o
`endif
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = BOOT_HOLD ? S_BOOT : S_RUN;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                w_ld_grant;
    logic                w_st_grant;
    logic                w_st_req_eff;
    logic                w_st_full;

    logic                r_st_done;
    logic                r_dtcm_we;
    logic [3:0]          r_dtcm_be;
    logic [WORD_AW-1:0]  r_dtcm_addr;
    logic [31:0]         r_dtcm_data;
    logic                r_itcm_we;
    logic [WORD_AW-1:0]  r_itcm_addr;
    logic [31:0]         r_itcm_data;

    logic [WORD_AW-1:0]  w_st_waddr;
    logic                w_unused_addr;

    assign w_st_waddr    = st_addr_i[WORD_AW+1:2];
    assign w_unused_addr = ^{st_addr_i[31:WORD_AW+2], st_addr_i[1:0]};
    assign w_st_full     = (st_mask_i == 4'hF);

    // The store being acknowledged this cycle is still presented by the core,
    // so it is masked to avoid granting it a second time.
    assign w_st_req_eff  = st_req_i & ~r_st_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RESET_STATE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_ld_grant  = 1'b0;
        w_st_grant  = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_ld_grant = ld_valid_i;
                w_wait_nxt = '0;
                if (ld_valid_i && ld_last_i) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (ld_valid_i && (r_wait == WAIT_LIMIT)) begin
                    w_ld_grant = 1'b1;
                end else if (w_st_req_eff) begin
                    w_st_grant = 1'b1;
                end else if (ld_valid_i) begin
                    w_ld_grant = 1'b1;
                end
                // The counter only moves while a loader beat is pending. It
                // holds its value while the loader is idle.
                if (w_ld_grant) begin
                    w_wait_nxt = '0;
                end else if (ld_valid_i && (r_wait != WAIT_LIMIT)) begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            default: begin
                w_state_nxt = RESET_STATE;
            end
        endcase
    end

    // In BOOT the loader is always ready. Ready is gated during reset so the
    // port reads 0 while rst is high.
    assign ld_ready_o  = ~rst & ((r_state == S_BOOT) | w_ld_grant);
    assign core_hold_o = (r_state == S_BOOT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st_done   <= 1'b0;
            r_dtcm_we   <= 1'b0;
            r_dtcm_be   <= '0;
            r_dtcm_addr <= '0;
            r_dtcm_data <= '0;
            r_itcm_we   <= 1'b0;
            r_itcm_addr <= '0;
            r_itcm_data <= '0;
        end else begin
            r_st_done <= w_st_grant;
            r_dtcm_we <= w_ld_grant | w_st_grant;
`ifdef TCM_ITCM_STORE_MIRROR_EN
            r_itcm_we <= w_ld_grant | (w_st_grant & w_st_full);
`else
            r_itcm_we <= w_ld_grant;
`endif
            if (w_ld_grant) begin
                r_dtcm_be   <= 4'hF;
                r_dtcm_addr <= ld_waddr_i;
                r_dtcm_data <= ld_data_i;
                r_itcm_addr <= ld_waddr_i;
                r_itcm_data <= ld_data_i;
            end else if (w_st_grant) begin
                r_dtcm_be   <= st_mask_i;
                r_dtcm_addr <= w_st_waddr;
                r_dtcm_data <= st_data_i;
`ifdef TCM_ITCM_STORE_MIRROR_EN
                if (w_st_full) begin
                    r_itcm_addr <= w_st_waddr;
                    r_itcm_data <= st_data_i;
                end
`endif
            end
        end
    end

`ifdef TCM_ITCM_STORE_MIRROR_EN
    logic               r_dirty;
    logic [WORD_AW-1:0] r_dirty_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dirty      <= 1'b0;
            r_dirty_addr <= '0;
        end else if (w_st_grant && !w_st_full) begin
            r_dirty      <= 1'b1;
            r_dirty_addr <= w_st_waddr;
        end else if (w_ld_grant && (ld_waddr_i == r_dirty_addr)) begin
            r_dirty <= 1'b0;
        end
    end

    assign itcm_stale_o = r_dirty;
`endif

    assign st_done_o   = r_st_done;
    assign dtcm_we_o   = r_dtcm_we;
    assign dtcm_be_o   = r_dtcm_be;
    assign dtcm_addr_o = r_dtcm_addr;
    assign dtcm_data_o = r_dtcm_data;
    assign itcm_we_o   = r_itcm_we;
    assign itcm_addr_o = r_itcm_addr;
    assign itcm_data_o = r_itcm_data;

endmodule

// File: doc/tcm_write_arbiter.md
Name: tcm_write_arbiter

Overview:
Sequences all writes into the dual-copy tightly coupled memory, which is one DTCM and one ITCM image of the same address space. It shares the DTCM store port between the core store path and an external loader. The loader is used for boot image download and debug patching, and each of its beats is mirrored into both copies. It also holds the core in a boot state until the image download completes.

Parameters:
WORD_AW, 14, word-address width of each TCM bank (TCM_SIZE*1024/4 entries).
MAX_WAIT, 4, max consecutive RUN cycles a pending loader beat may lose to core stores before it is forced through.
BOOT_HOLD, 1, 1 = start in BOOT with core held; 0 = start directly in RUN.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
st_req_i  in  1  core store request (level, held until done)
st_addr_i  in  32  core store byte address; bits [WORD_AW+1:2] used
st_data_i  in  32  core store data
st_mask_i  in  4  core store byte enables
st_done_o  out  1  store written this cycle (1-cycle pulse)
ld_valid_i  in  1  loader beat valid
ld_ready_o  out  1  loader beat accepted when valid & ready
ld_waddr_i  in  WORD_AW  loader word address
ld_data_i  in  32  loader data (full word)
ld_last_i  in  1  final beat of boot image
core_hold_o  out  1  keeps core fetch/stall asserted during BOOT
dtcm_we_o  out  1  DTCM port-2 write enable
dtcm_be_o  out  4  DTCM byte enables
dtcm_addr_o  out  WORD_AW  DTCM word address
dtcm_data_o  out  32  DTCM write data
itcm_we_o  out  1  ITCM port-2 write enable
itcm_addr_o  out  WORD_AW  ITCM word address
itcm_data_o  out  32  ITCM write data

Behaviour:
- One clock `clk`; reset `rst` is asynchronous, active-high.
- Reset values:
  - all *_we_o=0, be=0, addr=0, data=0;
  - st_done_o=0, ld_ready_o=0;
  - core_hold_o=BOOT_HOLD;
  - state=BOOT if BOOT_HOLD else RUN;
  - wait counter=0.
- State BOOT:
  - core_hold_o=1; core stores are ignored (no st_done_o).
  - ld_ready_o=1 combinationally.
  - Accepted beat: next cycle dtcm_we_o=itcm_we_o=1, be=4'hF, same addr/data on both.
  - Accepted beat with ld_last_i=1: move to RUN next cycle; core_hold_o falls in that same cycle.
- State RUN: each cycle at most one grant is issued.
  - Default priority: core store.
  - Forced loader: if ld_valid_i is pending and the wait counter equals MAX_WAIT, the loader wins. The counter clears on any loader grant and increments (saturating) per cycle a valid loader beat loses.
  - ld_ready_o is combinational: 1 exactly in the cycles the loader is granted.
  - Core store grant: the next cycle drives dtcm_we_o=1, be=st_mask_i, with st_addr/st_data registered. st_done_o pulses in that same output cycle; itcm_we_o=0.
  - The core drops or changes st_req_i after seeing st_done_o. The arbiter must not re-grant the same store in the done cycle, so st_req_i is masked in the cycle st_done_o=1.
  - Loader grant in RUN: identical dual write as in BOOT. ld_last_i is ignored in RUN.
- Latency: grant to SRAM write inputs = 1 cycle (registered outputs); the SRAM commits on the following edge.
- Boundary cases:
  - MAX_WAIT=0: the loader always wins when valid.
  - Back-to-back core stores: one store per 2 cycles worst case due to done masking.
  - Loader idle: the counter holds 0.
- Reset mid-write: outputs clear asynchronously. An in-flight write is dropped and no st_done_o is issued.

Optional Feature:
TCM_ITCM_STORE_MIRROR_EN
- Defined: core store writes also assert itcm_we_o with the same addr/data. This keeps ITCM coherent for self-modifying code.
  - ITCM lacks byte enables, so for a partial mask the block does not mirror. It holds an internal dirty flag and a sticky `itcm_stale_o` (extra 1-bit output, reset 0). The flag clears on the next loader write to that address.
- Undefined: itcm_we_o is driven only by loader writes, and the `itcm_stale_o` port is absent.

Test Plan:
- Boot: BOOT_HOLD=1, 3 loader beats to addr 0,1,2 with data 0xA0,0xA1,0xA2, last on beat 3 -> three dual writes with be=F, core_hold_o drops the cycle after the third write. st_req_i asserted during BOOT gets no st_done_o.
- Core store: RUN, st_addr=0x10, mask=4'b0011, data=0x1234 -> next cycle dtcm_we=1, addr=4, be=3, st_done_o=1, itcm_we=0.
- Starvation: MAX_WAIT=4, continuous core stores, loader valid -> loader granted no later than the 5th cycle and counter resets.
- Simultaneous: both requesters valid, counter=0 -> core granted, ld_ready_o=0, counter=1.
- Async reset mid-write: assert rst between a grant and its output cycle -> outputs clear immediately, no st_done_o, state=BOOT.
- Mirror (macro on): full-mask store to 0x20 -> itcm_we=1 addr=8. Half-mask store -> itcm_we=0, itcm_stale_o=1.
